fetch_sequencer: RTL

//  Sequences instruction fetch for the two synchronous-read instruction sources (BIOS, IMEM).

---
 rtl/fetch_sequencer_pkg.sv | 25 ++
 rtl/fetch_sequencer_if.sv | 43 ++++
 rtl/fetch_sequencer.sv | 102 ++++++++++
 3 files changed

// File: rtl/fetch_sequencer_pkg.sv
// ============================================================================
// Module  : fetch_sequencer_pkg
// Brief   : Shared types and constants for the instruction fetch sequencer.
// Revision: 1.0
// ============================================================================
`default_nettype none

package fetch_sequencer_pkg;

    typedef enum logic [1:0] {
        ST_BOOT  = 2'd0,
        ST_RUN   = 2'd1,
        ST_FLUSH = 2'd2
    } state_t;

    localparam logic [31:0] c_reset_pc_default = 32'h4000_0000;
    localparam int unsigned c_bios_sel_bit     = 30;

    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

`default_nettype wire

// File: rtl/fetch_sequencer_if.sv
// ============================================================================
// Module  : fetch_sequencer_if
// Brief   : Control/address bundle between fetch sequencer, memories and mux.
// Revision: 1.0
// ============================================================================
`default_nettype none

interface fetch_sequencer_if;

    logic        stall;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic [31:0] fetch_addr;
    logic [31:0] pc_f;
    logic        pc_30;
    logic        imux_nop;
    logic        inst_valid;

    modport master (
        input  stall,
        input  redirect,
        input  redirect_pc,
        output fetch_addr,
        output pc_f,
        output pc_30,
        output imux_nop,
        output inst_valid
    );

    modport slave (
        output stall,
        output redirect,
        output redirect_pc,
        input  fetch_addr,
        input  pc_f,
        input  pc_30,
        input  imux_nop,
        input  inst_valid
    );

endinterface

`default_nettype wire

// File: rtl/fetch_sequencer.sv
// ============================================================================
// Module  : fetch_sequencer
// Brief   : Fetch PC, shared read address and NOP/source control for BIOS/IMEM.
// Revision: 1.0
// ============================================================================
`default_nettype none

module fetch_sequencer
    import fetch_sequencer_pkg::*;
#(
    parameter logic [31:0] RESET_PC      = c_reset_pc_default,
    parameter int unsigned FLUSH_BUBBLES = 1
) (
    input  logic                   clk,
    input  logic                   rst,
    fetch_sequencer_if.master      fetch_bus
);

    localparam logic [2:0] c_flush_load     = 3'(FLUSH_BUBBLES - 1);
    localparam state_t     c_redirect_state = (FLUSH_BUBBLES > 1) ? ST_FLUSH : ST_RUN;

    logic [31:0] r_pc_f;
    state_t      r_state;
    logic [2:0]  r_cnt;

    logic [31:0] w_fetch_addr;
    logic [31:0] w_next_pc;
    logic [31:0] w_pc_plus4;
    state_t      w_next_state;
    logic [2:0]  w_next_cnt;
    logic        w_nop;

    assign w_pc_plus4 = r_pc_f + 32'd4;

    always_comb begin
        w_fetch_addr = r_pc_f;
        w_next_pc    = r_pc_f;
        w_next_state = r_state;
        w_next_cnt   = r_cnt;
        w_nop        = 1'b1;

        if (rst) begin
            w_fetch_addr = RESET_PC;
        end else if (fetch_bus.redirect) begin
            // The wrong-path word on the memory outputs is squashed this cycle.
            w_fetch_addr = word_align(fetch_bus.redirect_pc);
            w_next_pc    = word_align(fetch_bus.redirect_pc);
            w_next_state = c_redirect_state;
            w_next_cnt   = c_flush_load;
        end else begin
            case (r_state)
                ST_BOOT: begin
                    w_fetch_addr = RESET_PC;
                    w_next_state = ST_RUN;
                end
                ST_RUN: begin
                    w_nop = 1'b0;
                    if (!fetch_bus.stall) begin
                        w_fetch_addr = w_pc_plus4;
                        w_next_pc    = w_pc_plus4;
                    end
                end
                ST_FLUSH: begin
                    // Keep re-reading the target so it is on the outputs when bubbles end.
                    if (!fetch_bus.stall) begin
                        w_next_cnt = r_cnt - 3'd1;
                        if (r_cnt <= 3'd1) begin
                            w_next_state = ST_RUN;
                        end
                    end
                end
                default: begin
                    w_fetch_addr = RESET_PC;
                    w_next_pc    = RESET_PC;
                    w_next_state = ST_BOOT;
                    w_next_cnt   = 3'd0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pc_f  <= RESET_PC;
            r_state <= ST_BOOT;
            r_cnt   <= 3'd0;
        end else begin
            r_pc_f  <= w_next_pc;
            r_state <= w_next_state;
            r_cnt   <= w_next_cnt;
        end
    end

    assign fetch_bus.fetch_addr = w_fetch_addr;
    assign fetch_bus.pc_f       = r_pc_f;
    assign fetch_bus.pc_30      = r_pc_f[c_bios_sel_bit];
    assign fetch_bus.imux_nop   = w_nop;
    assign fetch_bus.inst_valid = ~w_nop & ~fetch_bus.stall;

endmodule

`default_nettype wire
